// File: rtl/pc_sequencer.sv
// Next-PC controller for the single-cycle MIPS datapath: owns the PC, issues
// fetches under a ready/stall handshake and traps misaligned JR targets.
module pc_sequencer #(
   parameter int          ADDR_WIDTH   = 32,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  imem_ready,
   input  logic                  stall,
   input  logic                  jump_en,
   input  logic [25:0]           jump_target,
   input  logic                  branch_en,
   input  logic [15:0]           branch_imm,
   input  logic                  jr_en,
   input  logic [ADDR_WIDTH-1:0] jr_target,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic                  fetch_valid,
   output logic                  exc_flag,
   output logic [ADDR_WIDTH-1:0] epc,
   output logic [31:0]           fetch_count
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_TRAP  = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] RST_PC  = ADDR_WIDTH'(RESET_VECTOR);
   localparam logic [ADDR_WIDTH-1:0] EXC_PC  = ADDR_WIDTH'(EXC_VECTOR);
   localparam logic [ADDR_WIDTH-1:0] LOW_28  = ADDR_WIDTH'(28'hFFF_FFFF);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]   epc_q, epc_d;
   logic [31:0]             count_q, count_d;

   logic                    accept;
   logic [ADDR_WIDTH-1:0]   p4;
   logic [ADDR_WIDTH-1:0]   jump_pc;
   logic [ADDR_WIDTH-1:0]   branch_pc;

   // Jump keeps the top bits of PC+4 above bit 27 and replaces the rest.
   always_comb begin
      p4        = pc_q + ADDR_WIDTH'(4);
      jump_pc   = (p4 & ~LOW_28) | ADDR_WIDTH'({jump_target, 2'b00});
      branch_pc = p4 + {{(ADDR_WIDTH-18){branch_imm[15]}}, branch_imm, 2'b00};
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      epc_d   = epc_q;
      count_d = count_q;
      accept  = (state_q == S_FETCH) && imem_ready && !stall;

      case (state_q)
         S_BOOT:  state_d = S_FETCH;
         S_TRAP:  state_d = S_FETCH;
         S_FETCH: begin
            if (accept) begin
               count_d = count_q + 32'd1;
               if (jr_en) begin
                  if (jr_target[1:0] != 2'b00) begin
                     pc_d    = EXC_PC;
                     epc_d   = pc_q;
                     state_d = S_TRAP;
                  end else begin
                     pc_d = jr_target;
                  end
               end else if (jump_en) begin
                  pc_d = jump_pc;
               end else if (branch_en) begin
                  pc_d = branch_pc;
               end else begin
                  pc_d = p4;
               end
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_BOOT;
         pc_q    <= RST_PC;
         epc_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         count_q <= count_d;
      end
   end

   assign pc_out      = pc_q;
   assign epc         = epc_q;
   assign fetch_count = count_q;
   assign fetch_valid = (state_q == S_FETCH);
   assign exc_flag    = (state_q == S_TRAP);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_ready;
   logic        stall;
   logic        jump_en;
   logic [25:0] jump_target;
   logic        branch_en;
   logic [15:0] branch_imm;
   logic        jr_en;
   logic [31:0] jr_target;
   logic [31:0] pc_out;
   logic        fetch_valid;
   logic        exc_flag;
   logic [31:0] epc;
   logic [31:0] fetch_count;

   int checks   = 0;
   int failures = 0;

   pc_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .imem_ready  (imem_ready),
      .stall       (stall),
      .jump_en     (jump_en),
      .jump_target (jump_target),
      .branch_en   (branch_en),
      .branch_imm  (branch_imm),
      .jr_en       (jr_en),
      .jr_target   (jr_target),
      .pc_out      (pc_out),
      .fetch_valid (fetch_valid),
      .exc_flag    (exc_flag),
      .epc         (epc),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   // Reference model: a bubble flag, a trap flag and plain PC arithmetic.
   logic        check_en = 1'b0;
   logic [31:0] m_pc, m_epc, m_cnt;
   logic        m_bubble, m_trap;

   always @(posedge clk) begin : model
      logic [31:0] p4;
      logic [31:0] off;
      p4  = m_pc + 32'd4;
      off = {{16{branch_imm[15]}}, branch_imm};
      if (rst) begin
         check_en <= 1'b1;
         m_pc     <= 32'h0;
         m_epc    <= 32'h0;
         m_cnt    <= 32'h0;
         m_bubble <= 1'b1;
         m_trap   <= 1'b0;
      end else if (m_bubble) begin
         m_bubble <= 1'b0;
      end else if (m_trap) begin
         m_trap <= 1'b0;
      end else if (imem_ready && !stall) begin
         m_cnt <= m_cnt + 32'd1;
         if (jr_en && (jr_target % 4 != 0)) begin
            m_trap <= 1'b1;
            m_epc  <= m_pc;
            m_pc   <= 32'h180;
         end else if (jr_en)
            m_pc <= jr_target;
         else if (jump_en)
            m_pc <= (p4 & 32'hF000_0000) | (32'(jump_target) * 4);
         else if (branch_en)
            m_pc <= p4 + off * 4;
         else
            m_pc <= p4;
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         cmp("model_pc_out",      pc_out,             m_pc);
         cmp("model_fetch_valid", 32'(fetch_valid),   32'(!m_bubble && !m_trap));
         cmp("model_exc_flag",    32'(exc_flag),      32'(m_trap));
         cmp("model_epc",         epc,                m_epc);
         cmp("model_fetch_count", fetch_count,        m_cnt);
      end
   end

   // Drive one cycle of inputs at the falling edge, return at the next falling edge.
   task automatic applyStimulus(input logic r, input logic rdy, input logic stl,
                                input logic je, input logic [25:0] jt,
                                input logic be, input logic [15:0] bi,
                                input logic jre, input logic [31:0] jrt);
      rst = r; imem_ready = rdy; stall = stl;
      jump_en = je; jump_target = jt;
      branch_en = be; branch_imm = bi;
      jr_en = jre; jr_target = jrt;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic seqStep();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0, 32'h0);
   endtask

   task automatic jrStep(input logic [31:0] t);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1, t);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] pc, input logic fv,
                              input logic ex, input logic [31:0] ep, input logic [31:0] cnt);
      cmp({name, "_pc"},  pc_out,           pc);
      cmp({name, "_fv"},  32'(fetch_valid), 32'(fv));
      cmp({name, "_exc"}, 32'(exc_flag),    32'(ex));
      cmp({name, "_epc"}, epc,              ep);
      cmp({name, "_cnt"}, fetch_count,      cnt);
   endtask

   initial begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0, 32'h0);
      checkOutput("reset", 32'h0, 1'b0, 1'b0, 32'h0, 32'd0);
      rst = 1'b0;
      #1;
      cmp("bubble_fv", 32'(fetch_valid), 32'd0);
      @(negedge clk);
      checkOutput("first_fetch", 32'h0, 1'b1, 1'b0, 32'h0, 32'd0);
      seqStep(); checkOutput("seq1", 32'h4, 1'b1, 1'b0, 32'h0, 32'd1);
      seqStep(); checkOutput("seq2", 32'h8, 1'b1, 1'b0, 32'h0, 32'd2);
      seqStep(); seqStep();
      checkOutput("at_0x10", 32'h10, 1'b1, 1'b0, 32'h0, 32'd4);

      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1, 32'h0000_0400);
      checkOutput("not_ready_hold", 32'h10, 1'b1, 1'b0, 32'h0, 32'd4);
      for (int i = 0; i < 2; i++)
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 26'h55, 1'b0, 16'h0, 1'b0, 32'h0);
      checkOutput("stall_hold", 32'h10, 1'b1, 1'b0, 32'h0, 32'd4);
      seqStep(); checkOutput("after_stall", 32'h14, 1'b1, 1'b0, 32'h0, 32'd5);

      jrStep(32'h1000_0040);
      checkOutput("jr_aligned", 32'h1000_0040, 1'b1, 1'b0, 32'h0, 32'd6);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 26'h100, 1'b0, 16'h0, 1'b0, 32'h0);
      checkOutput("jump", 32'h1000_0400, 1'b1, 1'b0, 32'h0, 32'd7);
      jrStep(32'h1000_0040);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 26'h0, 1'b1, 16'hFFFE, 1'b0, 32'h0);
      checkOutput("branch_neg", 32'h1000_003C, 1'b1, 1'b0, 32'h0, 32'd9);
      jrStep(32'h1000_0040);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 26'h100, 1'b1, 16'hFFFE, 1'b0, 32'h0);
      checkOutput("jump_over_branch", 32'h1000_0400, 1'b1, 1'b0, 32'h0, 32'd11);

      jrStep(32'h0000_0200);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 26'h3, 1'b1, 16'h7, 1'b1, 32'h0000_0302);
      checkOutput("trap", 32'h180, 1'b0, 1'b1, 32'h200, 32'd13);
      seqStep();
      checkOutput("after_trap", 32'h180, 1'b1, 1'b0, 32'h200, 32'd13);
      jrStep(32'h0000_0200);
      jrStep(32'h0000_0300);
      checkOutput("jr_no_trap", 32'h300, 1'b1, 1'b0, 32'h200, 32'd15);

      jrStep(32'hFFFF_FFFC);
      seqStep();
      checkOutput("pc_wrap", 32'h0, 1'b1, 1'b0, 32'h200, 32'd17);

      jrStep(32'h0000_0001);
      checkOutput("trap2", 32'h180, 1'b0, 1'b1, 32'h0, 32'd18);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0, 32'h0);
      checkOutput("reset_mid_trap", 32'h0, 1'b0, 1'b0, 32'h0, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         t = $urandom;
         if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
         applyStimulus($urandom_range(0, 99) == 0,
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 5) == 0,
                       $urandom_range(0, 4) == 0, 26'($urandom),
                       $urandom_range(0, 3) == 0, 16'($urandom),
                       $urandom_range(0, 7) == 0, t);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
